// File: rtl/pio_irq_servicer_pkg.sv
// Register map of the edge-capture PIO slave and the servicer FSM state encoding.
package pio_regs_pkg;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD_CAP,
      ST_WAIT_CAP,
      ST_CLR,
      ST_RD_DAT,
      ST_WAIT_DAT,
      ST_PUSH
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pio_irq_servicer_if.sv
// Avalon-MM master bus, PIO interrupt line and downstream event handshake of the servicer.
interface pio_irq_servicer_if #(parameter int DATA_W = 2);
   logic [1:0]        avm_address;
   logic              avm_chipselect;
   logic              avm_write_n;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              irq;
   logic              ev_valid;
   logic              ev_ready;
   logic [DATA_W-1:0] ev_edges;
   logic [DATA_W-1:0] ev_data;
   logic [15:0]       ev_count;
   logic [7:0]        spurious_count;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, irq,
      output ev_valid, ev_edges, ev_data, ev_count, spurious_count,
      input  ev_ready
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, irq,
      input  ev_valid, ev_edges, ev_data, ev_count, spurious_count,
      output ev_ready
   );
endinterface

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master servicing an edge-capture PIO: programs irq_mask, then on irq reads,
// write-1-clears and reports captured edges together with the data register as a valid/ready event.
module pio_irq_servicer
   import pio_regs_pkg::*;
#(
   parameter int                DATA_W       = 2,
   parameter logic [DATA_W-1:0] IRQ_MASK     = {DATA_W{1'b1}},
   parameter int                READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   pio_irq_servicer_if.master  bus
);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_lat;
   logic [DATA_W-1:0] r_cap, r_edges, r_data;
   logic [15:0]       r_ev_count;
   logic [7:0]        r_spur;
   logic [DATA_W-1:0] w_rd, w_cap;
   logic              w_lat_done;
   logic              w_cs, w_wn;
   logic [1:0]        w_addr;
   logic [31:0]       w_wdata;
   logic              w_unused;

   assign w_rd       = bus.avm_readdata[DATA_W-1:0];
   assign w_cap      = w_rd & IRQ_MASK;
   assign w_lat_done = (r_lat == 3'(READ_LATENCY));
   assign w_unused   = &{1'b0, bus.avm_readdata};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_INIT;
      else       r_state <= w_state_nxt;
   end

   // Read address stays on the bus through the wait states until readdata is sampled.
   always_comb begin
      w_state_nxt = r_state;
      w_cs        = 1'b0;
      w_wn        = 1'b1;
      w_addr      = PIO_ADDR_DATA;
      w_wdata     = '0;
      case (r_state)
         ST_INIT: begin
            w_cs        = 1'b1;
            w_wn        = 1'b0;
            w_addr      = PIO_ADDR_MASK;
            w_wdata     = 32'(IRQ_MASK);
            w_state_nxt = ST_IDLE;
         end
         ST_IDLE: if (bus.irq) w_state_nxt = ST_RD_CAP;
         ST_RD_CAP: begin
            w_cs        = 1'b1;
            w_addr      = PIO_ADDR_EDGE;
            w_state_nxt = ST_WAIT_CAP;
         end
         ST_WAIT_CAP: begin
            w_addr = PIO_ADDR_EDGE;
            if (w_lat_done) w_state_nxt = (w_cap == '0) ? ST_IDLE : ST_CLR;
         end
         ST_CLR: begin
            w_cs        = 1'b1;
            w_wn        = 1'b0;
            w_addr      = PIO_ADDR_EDGE;
            w_wdata     = 32'(r_cap);
            w_state_nxt = ST_RD_DAT;
         end
         ST_RD_DAT: begin
            w_cs        = 1'b1;
            w_addr      = PIO_ADDR_DATA;
            w_state_nxt = ST_WAIT_DAT;
         end
         ST_WAIT_DAT: begin
            w_addr = PIO_ADDR_DATA;
            if (w_lat_done) w_state_nxt = ST_PUSH;
         end
         ST_PUSH: if (bus.ev_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lat      <= '0;
         r_cap      <= '0;
         r_edges    <= '0;
         r_data     <= '0;
         r_ev_count <= '0;
         r_spur     <= '0;
      end else begin
         case (r_state)
            ST_RD_CAP, ST_RD_DAT: r_lat <= 3'd1;
            ST_WAIT_CAP: begin
               if (w_lat_done) begin
                  r_cap <= w_cap;
                  if (w_cap == '0) r_spur <= sat_inc8(r_spur);
               end else begin
                  r_lat <= r_lat + 3'd1;
               end
            end
            ST_WAIT_DAT: begin
               if (w_lat_done) begin
                  r_edges <= r_cap;
                  r_data  <= w_rd;
               end else begin
                  r_lat <= r_lat + 3'd1;
               end
            end
            ST_PUSH: if (bus.ev_ready) r_ev_count <= sat_inc16(r_ev_count);
            default: ;
         endcase
      end
   end

   // INIT drives the mask write, so the bus is gated while reset is held to keep it idle.
   assign bus.avm_chipselect = w_cs & ~reset;
   assign bus.avm_write_n    = w_wn | reset;
   assign bus.avm_address    = reset ? 2'd0 : w_addr;
   assign bus.avm_writedata  = reset ? 32'd0 : w_wdata;

   assign bus.ev_valid       = (r_state == ST_PUSH);
   assign bus.ev_edges       = r_edges;
   assign bus.ev_data        = r_data;
   assign bus.ev_count       = r_ev_count;
   assign bus.spurious_count = r_spur;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Three servicer instances (default / mask 01 / latency 3), each against a behavioural edge-capture PIO.
module tb_pio_irq_servicer;

   logic clk = 1'b0;
   logic rst, srst;
   always #5 clk = ~clk;

   logic [2:0][1:0]  pin;
   logic [2:0]       irq_force, ev_ready_v;
   logic [2:0]       ev_valid_v, cs_v, wn_v;
   logic [2:0][1:0]  addr_v, ev_edges_v, ev_data_v, edge_v, lastclr_v;
   logic [2:0][31:0] wdata_v, wm_data_v;
   logic [2:0][15:0] ev_count_v, n_wm_v, n_wc_v, n_rd_v, n_bus_v;
   logic [2:0][7:0]  spur_v;

   int pass_cnt = 0;
   int total_cnt = 0;

   for (genvar g = 0; g < 3; g++) begin : g_i
      localparam logic [1:0] MASK = (g == 1) ? 2'b01 : 2'b11;
      localparam int         LAT  = (g == 2) ? 3 : 1;

      pio_irq_servicer_if #(.DATA_W(2)) bus ();
      pio_irq_servicer #(.DATA_W(2), .IRQ_MASK(MASK), .READ_LATENCY(LAT)) u_dut (
         .clk(clk), .reset(rst), .bus(bus.master));

      logic [1:0]  s_prev, s_edge, s_mask, s_lastclr, s_clr, s_val;
      logic [31:0] s_junk, s_wm_data;
      logic [31:0] s_rd [1:3];
      logic [15:0] n_wm, n_wc, n_rd, n_bus;
      logic        s_wr, s_rdq;

      assign s_wr  = bus.avm_chipselect && !bus.avm_write_n;
      assign s_rdq = bus.avm_chipselect && bus.avm_write_n;
      assign s_clr = (s_wr && bus.avm_address == 2'd3) ? bus.avm_writedata[1:0] : 2'b00;
      always_comb begin
         s_val = 2'b00;
         case (bus.avm_address)
            2'd0:    s_val = pin[g];
            2'd2:    s_val = s_mask;
            2'd3:    s_val = s_edge;
            default: s_val = 2'b00;
         endcase
      end

      always @(posedge clk) begin
         s_junk <= $urandom;
         if (srst) begin
            s_prev <= pin[g]; s_edge <= '0; s_mask <= '0; s_lastclr <= '0; s_wm_data <= '0;
            n_wm <= '0; n_wc <= '0; n_rd <= '0; n_bus <= '0;
         end else begin
            s_prev <= pin[g];
            s_edge <= (s_edge & ~s_clr) | (pin[g] & ~s_prev);
            if (bus.avm_chipselect) n_bus <= n_bus + 16'd1;
            if (s_wr && bus.avm_address == 2'd2) begin
               s_mask <= bus.avm_writedata[1:0]; s_wm_data <= bus.avm_writedata; n_wm <= n_wm + 16'd1;
            end
            if (s_wr && bus.avm_address == 2'd3) begin
               s_lastclr <= bus.avm_writedata[1:0]; n_wc <= n_wc + 16'd1;
            end
            if (s_rdq) n_rd <= n_rd + 16'd1;
         end
         s_rd[1] <= s_rdq ? {s_junk[31:2], s_val} : s_junk;
         s_rd[2] <= s_rd[1];
         s_rd[3] <= s_rd[2];
      end

      assign bus.avm_readdata = s_rd[LAT];
      assign bus.irq          = (|(s_edge & s_mask)) | irq_force[g];
      assign bus.ev_ready     = ev_ready_v[g];

      assign ev_valid_v[g] = bus.ev_valid;
      assign ev_edges_v[g] = bus.ev_edges;
      assign ev_data_v[g]  = bus.ev_data;
      assign ev_count_v[g] = bus.ev_count;
      assign spur_v[g]     = bus.spurious_count;
      assign cs_v[g]       = bus.avm_chipselect;
      assign wn_v[g]       = bus.avm_write_n;
      assign addr_v[g]     = bus.avm_address;
      assign wdata_v[g]    = bus.avm_writedata;
      assign edge_v[g]     = s_edge;
      assign lastclr_v[g]  = s_lastclr;
      assign wm_data_v[g]  = s_wm_data;
      assign n_wm_v[g]     = n_wm;
      assign n_wc_v[g]     = n_wc;
      assign n_rd_v[g]     = n_rd;
      assign n_bus_v[g]    = n_bus;
   end

   task automatic make_rise(input int g, input int b);
      pin[g][b] = 1'b0;
      repeat (2) @(negedge clk);
      pin[g][b] = 1'b1;
   endtask

   task automatic wait_valid(input int g, input string name);
      int n = 0;
      while (!ev_valid_v[g] && n < 200) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (ev_valid_v[g] !== 1'b1) $display("FAIL %s_timeout: ev_valid got %b expected 1", name, ev_valid_v[g]);
      else pass_cnt++;
   endtask

   task automatic accept(input int g);
      ev_ready_v[g] = 1'b1;
      @(negedge clk);
      ev_ready_v[g] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; srst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({cs_v[0], wn_v[0], addr_v[0], wdata_v[0]} !== {1'b0, 1'b1, 2'd0, 32'd0})
         $display("FAIL reset_bus: cs/wn/addr/wdata got %b/%b/%0d/%h expected 0/1/0/0",
                  cs_v[0], wn_v[0], addr_v[0], wdata_v[0]);
      else pass_cnt++;
      total_cnt++;
      if ({ev_valid_v[0], ev_edges_v[0], ev_data_v[0], ev_count_v[0], spur_v[0]} !== '0)
         $display("FAIL reset_ev: valid/edges/data/count/spur got %b/%b/%b/%0d/%0d expected all 0",
                  ev_valid_v[0], ev_edges_v[0], ev_data_v[0], ev_count_v[0], spur_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_init();
      rst = 1'b0; srst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (n_wm_v[0] !== 16'd1 || wm_data_v[0] !== 32'h3)
         $display("FAIL init_mask_write: writes=%0d data=%h expected 1 write of 00000003", n_wm_v[0], wm_data_v[0]);
      else pass_cnt++;
      total_cnt++;
      if (wm_data_v[1] !== 32'h1) $display("FAIL init_mask1: data got %h expected 00000001", wm_data_v[1]);
      else pass_cnt++;
      repeat (10) @(negedge clk);
      total_cnt++;
      if (n_bus_v[0] !== 16'd1) $display("FAIL init_quiet: bus accesses got %0d expected 1", n_bus_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_single_edge();
      logic [15:0] rd0 = n_rd_v[0], wc0 = n_wc_v[0];
      pin[0][0] = 1'b1;
      wait_valid(0, "edge");
      total_cnt++;
      if (ev_edges_v[0] !== 2'b01 || ev_data_v[0] !== 2'b01)
         $display("FAIL edge_event: edges/data got %b/%b expected 01/01", ev_edges_v[0], ev_data_v[0]);
      else pass_cnt++;
      total_cnt++;
      if (n_rd_v[0] - rd0 !== 16'd2 || n_wc_v[0] - wc0 !== 16'd1 || lastclr_v[0] !== 2'b01)
         $display("FAIL edge_bus: reads=%0d clears=%0d clrdata=%b expected 2/1/01",
                  n_rd_v[0] - rd0, n_wc_v[0] - wc0, lastclr_v[0]);
      else pass_cnt++;
      accept(0);
      total_cnt++;
      if (ev_valid_v[0] !== 1'b0 || ev_count_v[0] !== 16'd1)
         $display("FAIL edge_accept: valid/count got %b/%0d expected 0/1", ev_valid_v[0], ev_count_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [15:0] b0;
      int bad = 0;
      make_rise(0, 0);
      wait_valid(0, "bp_first");
      b0 = n_bus_v[0];
      for (int i = 0; i < 20; i++) begin
         if (i == 5) pin[0][1] = 1'b1;
         @(negedge clk);
         if (ev_valid_v[0] !== 1'b1 || ev_edges_v[0] !== 2'b01 || ev_data_v[0] !== 2'b01) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles expected 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (n_bus_v[0] !== b0) $display("FAIL bp_no_bus: accesses got %0d expected %0d", n_bus_v[0], b0);
      else pass_cnt++;
      accept(0);
      wait_valid(0, "bp_second");
      total_cnt++;
      if (ev_edges_v[0] !== 2'b10 || ev_data_v[0] !== 2'b11)
         $display("FAIL bp_second: edges/data got %b/%b expected 10/11", ev_edges_v[0], ev_data_v[0]);
      else pass_cnt++;
      accept(0);
      total_cnt++;
      if (ev_count_v[0] !== 16'd3) $display("FAIL bp_count: got %0d expected 3", ev_count_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_spurious();
      logic [15:0] rd0 = n_rd_v[1], wc0 = n_wc_v[1];
      pin[1] = 2'b10;
      repeat (3) @(negedge clk);
      irq_force[1] = 1'b1;
      @(negedge clk);
      irq_force[1] = 1'b0;
      repeat (8) @(negedge clk);
      total_cnt++;
      if (spur_v[1] !== 8'd1 || ev_valid_v[1] !== 1'b0)
         $display("FAIL spur_count: spur/valid got %0d/%b expected 1/0", spur_v[1], ev_valid_v[1]);
      else pass_cnt++;
      total_cnt++;
      if (n_rd_v[1] - rd0 !== 16'd1 || n_wc_v[1] - wc0 !== 16'd0)
         $display("FAIL spur_bus: reads=%0d clears=%0d expected 1/0", n_rd_v[1] - rd0, n_wc_v[1] - wc0);
      else pass_cnt++;
      make_rise(1, 0);
      wait_valid(1, "spur_after");
      total_cnt++;
      if (ev_edges_v[1] !== 2'b01 || ev_data_v[1] !== 2'b11 || lastclr_v[1] !== 2'b01 || edge_v[1] !== 2'b10)
         $display("FAIL spur_after: edges/data/clr/pio_edge got %b/%b/%b/%b expected 01/11/01/10",
                  ev_edges_v[1], ev_data_v[1], lastclr_v[1], edge_v[1]);
      else pass_cnt++;
      accept(1);
   endtask

   task automatic test_reset_midway();
      logic [15:0] wm0;
      int n = 0, extra = 0;
      pin[0] = 2'b00;
      repeat (3) @(negedge clk);
      pin[0] = 2'b01;
      while (!(cs_v[0] && wn_v[0] && addr_v[0] == 2'd0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      pin[0] = 2'b11;
      wm0 = n_wm_v[0];
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total_cnt++;
      if ({cs_v[0], wn_v[0], addr_v[0], ev_valid_v[0], ev_count_v[0]} !== {1'b0, 1'b1, 2'd0, 1'b0, 16'd0})
         $display("FAIL midreset_outputs: cs/wn/addr/valid/count got %b/%b/%0d/%b/%0d expected 0/1/0/0/0",
                  cs_v[0], wn_v[0], addr_v[0], ev_valid_v[0], ev_count_v[0]);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_valid(0, "midreset_event");
      total_cnt++;
      if (ev_edges_v[0] !== 2'b10 || ev_data_v[0] !== 2'b11 || n_wm_v[0] - wm0 !== 16'd1)
         $display("FAIL midreset_event: edges/data/maskwrites got %b/%b/%0d expected 10/11/1",
                  ev_edges_v[0], ev_data_v[0], n_wm_v[0] - wm0);
      else pass_cnt++;
      accept(0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ev_valid_v[0]) extra++;
      end
      total_cnt++;
      if (extra != 0 || ev_count_v[0] !== 16'd1)
         $display("FAIL midreset_once: extra valid cycles/count got %0d/%0d expected 0/1", extra, ev_count_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_random_lat3();
      logic [1:0] rises = '0, seen = '0, nv;
      int n_acc = 0, bad = 0;
      for (int i = 0; i < 300; i++) begin
         nv = 2'($urandom_range(0, 3));
         rises |= nv & ~pin[2];
         pin[2] = nv;
         for (int k = $urandom_range(1, 4); k > 0; k--) begin
            ev_ready_v[2] = 1'($urandom_range(0, 1));
            if (ev_valid_v[2] && ev_ready_v[2]) begin
               seen |= ev_edges_v[2];
               n_acc++;
               if (ev_edges_v[2] == 2'b00) bad++;
            end
            @(negedge clk);
         end
      end
      ev_ready_v[2] = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if (ev_valid_v[2]) begin
            seen |= ev_edges_v[2];
            n_acc++;
            if (ev_edges_v[2] == 2'b00) bad++;
         end
         @(negedge clk);
      end
      ev_ready_v[2] = 1'b0;
      total_cnt++;
      if (seen !== rises) $display("FAIL rand_or_sum: got %b expected %b", seen, rises);
      else pass_cnt++;
      total_cnt++;
      if (bad != 0 || edge_v[2] !== 2'b00)
         $display("FAIL rand_drain: empty events=%0d pio_edge=%b expected 0/00", bad, edge_v[2]);
      else pass_cnt++;
      total_cnt++;
      if (ev_count_v[2] !== 16'(n_acc)) $display("FAIL rand_count: got %0d expected %0d", ev_count_v[2], n_acc);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      @(negedge clk);
      force g_i[2].u_dut.r_ev_count = 16'hFFFE;
      @(negedge clk);
      release g_i[2].u_dut.r_ev_count;
      for (int j = 0; j < 2; j++) begin
         make_rise(2, 0);
         wait_valid(2, "sat_event");
         accept(2);
         total_cnt++;
         if (ev_count_v[2] !== 16'hFFFF) $display("FAIL sat_count%0d: got %h expected ffff", j, ev_count_v[2]);
         else pass_cnt++;
      end
   endtask

   initial begin
      pin = '0; irq_force = '0; ev_ready_v = '0;
      test_reset();
      test_init();
      test_single_edge();
      test_backpressure();
      test_spurious();
      test_reset_midway();
      test_random_lat3();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
